// File: rtl/bram_line_packer_if.sv
// Value-stream handshake into bram_line_packer: the producer drives data/valid, the packer drives ready.
interface bram_line_packer_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bram_line_packer.sv
// Packs 16 consecutive 32-bit values into a 512-bit BRAM line with the 12-bit line address in [511:500].
// Define BRAM_LINE_PACKER_SAT_LANE15_EN to saturate lane 15 to 20'hFFFFF and expose sticky lane15_ovf.
module bram_line_packer #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 12,
    parameter logic [DATA_W-1:0] PAD_VALUE = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W+4:0]   num_words,
    bram_line_packer_if.slave   in_if,
    output logic [511:0]        data_out,
    output logic                we_out,
    output logic                busy,
    output logic                done
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
    ,
    output logic                lane15_ovf
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 5;
    localparam int unsigned NLOW  = 15;

    typedef enum logic [1:0] {StIdle, StFill, StEmit, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     line_addr_q, line_addr_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [3:0]            lane_q, lane_d;
    logic [DATA_W-1:0]     buf_q [NLOW];
    logic [DATA_W-1:0]     buf_d [NLOW];
    logic [19:0]           lane15_q, lane15_d;
    logic [511:0]          data_out_q, data_out_d;
    logic                  busy_q, busy_d;
    logic                  emit_now;
    logic [19:0]           lane15_val;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
    logic                  ovf_q, ovf_d;
    logic                  lane15_sat;
`endif

`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
    // Saturate so that "infinite" distances stay infinite after narrowing to 20 bits.
    always_comb begin
        lane15_sat = |in_if.in_data[DATA_W-1:20];
        lane15_val = lane15_sat ? 20'hFFFFF : in_if.in_data[19:0];
    end
`else
    always_comb begin
        lane15_val = in_if.in_data[19:0];
    end
`endif

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        lane15_d    = lane15_q;
        busy_d      = busy_q;
        emit_now    = 1'b0;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
                    ovf_d = 1'b0;
`endif
                    if (num_words != '0) begin
                        state_d     = StFill;
                        line_addr_d = base_addr;
                        remaining_d = num_words;
                        lane_d      = 4'd0;
                        busy_d      = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFill: begin
                if (in_if.in_valid) begin
                    if (lane_q == 4'd15) begin
                        lane15_d = lane15_val;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
                        if (lane15_sat) ovf_d = 1'b1;
`endif
                    end else begin
                        buf_d[lane_q] = in_if.in_data;
                    end
                    lane_d      = lane_q + 4'd1;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (lane_q == 4'd15 || remaining_q == CNT_W'(1)) begin
                        state_d  = StEmit;
                        emit_now = 1'b1;
                    end
                end
            end
            StEmit: begin
                // Refill unconditionally so a later transfer always starts from a padded line.
                for (int i = 0; i < int'(NLOW); i++) buf_d[i] = PAD_VALUE;
                lane15_d = PAD_VALUE[19:0];
                lane_d   = 4'd0;
                if (remaining_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d     = StFill;
                    line_addr_d = line_addr_q + ADDR_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // The line is captured on the completing transfer so it is valid during the EMIT cycle.
    always_comb begin
        data_out_d = data_out_q;
        if (emit_now) begin
            for (int i = 0; i < int'(NLOW); i++) data_out_d[i*DATA_W +: DATA_W] = buf_d[i];
            data_out_d[499:480] = lane15_d;
            data_out_d[511:500] = line_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            line_addr_q <= '0;
            remaining_q <= '0;
            lane_q      <= '0;
            for (int i = 0; i < int'(NLOW); i++) buf_q[i] <= PAD_VALUE;
            lane15_q    <= PAD_VALUE[19:0];
            data_out_q  <= '0;
            busy_q      <= 1'b0;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            lane15_q    <= lane15_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_if.in_ready = (state_q == StFill);
    assign we_out         = (state_q == StEmit);
    assign done           = (state_q == StDone);
    assign busy           = busy_q;
    assign data_out       = data_out_q;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
    assign lane15_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_bram_line_packer.sv
// Directed self-checking bench for bram_line_packer; also covers BRAM_LINE_PACKER_SAT_LANE15_EN builds.
module tb_bram_line_packer;

    localparam logic [31:0] PAD = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [11:0]  base_addr = '0;
    logic [16:0]  num_words = '0;
    logic [511:0] data_out;
    logic         we_out;
    logic         busy;
    logic         done;
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
    logic         lane15_ovf;
`endif

    bram_line_packer_if #(.DATA_W(32)) in_if ();

    bram_line_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .in_if      (in_if),
        .data_out   (data_out),
        .we_out     (we_out),
        .busy       (busy),
        .done       (done)
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
        ,
        .lane15_ovf (lane15_ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor, sampled mid-cycle.
    logic [511:0] lines [$];
    int           we_cyc [$];
    int           done_cyc;
    int           busy_seen;
    int           emit_ready_bad;
    always @(negedge clk) begin
        if (we_out) begin
            lines.push_back(data_out);
            we_cyc.push_back(cyc);
            if (in_if.in_ready) emit_ready_bad++;
        end
        if (done) done_cyc = cyc;
        if (busy) busy_seen = 1;
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [511:0] mk_line(input logic [11:0] addr, input logic [31:0] first,
                                             input int n);
        logic [511:0] l;
        logic [31:0]  v;
        for (int i = 0; i < 15; i++) l[i*32 +: 32] = (i < n) ? first + 32'(i) : PAD;
        v = first + 32'd15;
        l[499:480] = (n > 15) ? v[19:0] : 20'hFFFFF;
        l[511:500] = addr;
        return l;
    endfunction

    task automatic clear_mon();
        lines.delete();
        we_cyc.delete();
        done_cyc = -1;
        busy_seen = 0;
        emit_ready_bad = 0;
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_start(input logic [11:0] a, input logic [16:0] n, output int s_edge);
        start = 1'b1;
        base_addr = a;
        num_words = n;
        @(posedge clk);
        #1;
        s_edge = cyc;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] v, input int gap, output int acc_cycle);
        int t;
        in_if.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_if.in_data = v;
        in_if.in_valid = 1'b1;
        t = 0;
        while (!in_if.in_ready && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_if.in_ready) begin
            check("ready_timeout", 512'(0), 512'(1));
            in_if.in_valid = 1'b0;
            acc_cycle = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cycle = cyc - 1;
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 512'(0), 512'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, a, first_acc;
        in_if.in_data = '0;
        in_if.in_valid = 1'b0;
        clear_mon();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 512'(0));
        check("rst_we_out", 512'(we_out), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_in_ready", 512'(in_if.in_ready), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full single line; a start pulse while busy must be ignored.
        clear_mon();
        do_start(12'h005, 17'd16, s);
        first_acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                start = 1'b1;
                base_addr = 12'h007;
                num_words = 17'd3;
            end
            push(32'(i), 0, a);
            start = 1'b0;
            if (i == 0) first_acc = a;
        end
        wait_done();
        check("t1_we_count", 512'(lines.size()), 512'(1));
        if (lines.size() >= 1) check("t1_line", lines[0], mk_line(12'h005, 32'd0, 16));
        if (we_cyc.size() >= 1) begin
            check("t1_we_latency", 512'(we_cyc[0] - first_acc), 512'(16));
            check("t1_done_after_we", 512'(done_cyc - we_cyc[0]), 512'(1));
        end
        check("t1_busy_seen", 512'(busy_seen), 512'(1));
        check("t1_busy_idle", 512'(busy), 512'(0));

        // Partial second line with address wrap.
        clear_mon();
        do_start(12'hFFF, 17'd20, s);
        for (int i = 0; i < 20; i++) push(32'(100 + i), 0, a);
        wait_done();
        check("t2_we_count", 512'(lines.size()), 512'(2));
        if (lines.size() >= 2) begin
            check("t2_line0", lines[0], mk_line(12'hFFF, 32'd100, 16));
            check("t2_line1", lines[1], mk_line(12'h000, 32'd116, 4));
        end
        check("t2_emit_not_ready", 512'(emit_ready_bad), 512'(0));

        // Bubbles on in_valid give the same packed line.
        clear_mon();
        do_start(12'h005, 17'd16, s);
        for (int i = 0; i < 16; i++) push(32'(i), (i == 0) ? 0 : 1, a);
        wait_done();
        check("t3_we_count", 512'(lines.size()), 512'(1));
        if (lines.size() >= 1) check("t3_line", lines[0], mk_line(12'h005, 32'd0, 16));
        check("t3_emit_not_ready", 512'(emit_ready_bad), 512'(0));

        // Zero-length transfer.
        clear_mon();
        do_start(12'h123, 17'd0, s);
        wait_done();
        check("t4_done_latency", 512'(done_cyc - (s - 1)), 512'(1));
        check("t4_we_count", 512'(lines.size()), 512'(0));
        check("t4_busy_never", 512'(busy_seen), 512'(0));

        // Reset mid-transfer discards the partial line.
        clear_mon();
        do_start(12'h005, 17'd16, s);
        for (int i = 0; i < 7; i++) push(32'(50 + i), 0, a);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data_out", data_out, 512'(0));
        check("t5_rst_busy", 512'(busy), 512'(0));
        check("t5_rst_in_ready", 512'(in_if.in_ready), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_no_we", 512'(lines.size()), 512'(0));
        clear_mon();
        do_start(12'h010, 17'd16, s);
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i), 0, a);
        wait_done();
        check("t5_we_count", 512'(lines.size()), 512'(1));
        if (lines.size() >= 1) check("t5_line", lines[0], mk_line(12'h010, 32'h200, 16));

        // Lane 15 narrowing.
        clear_mon();
        do_start(12'h020, 17'd16, s);
        for (int i = 0; i < 15; i++) push(32'(i), 0, a);
        push(32'h0012_3456, 0, a);
        wait_done();
        check("t6_we_count", 512'(lines.size()), 512'(1));
`ifdef BRAM_LINE_PACKER_SAT_LANE15_EN
        if (lines.size() >= 1) check("t6_lane15_sat", 512'(lines[0][499:480]), 512'(20'hFFFFF));
        check("t6_ovf_set", 512'(lane15_ovf), 512'(1));
        do_start(12'h000, 17'd0, s);
        check("t6_ovf_cleared", 512'(lane15_ovf), 512'(0));
        wait_done();
`else
        if (lines.size() >= 1) check("t6_lane15_trunc", 512'(lines[0][499:480]), 512'(20'h23456));
`endif
        if (lines.size() >= 1) check("t6_addr", 512'(lines[0][511:500]), 512'(12'h020));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_line_packer.md
Name: bram_line_packer

Overview:
- Write-side companion of the 16-bank vertex BRAM.
- Accepts a sequential stream of 32-bit vertex values over a valid/ready handshake and packs every 16 consecutive values into one 512-bit line.
- Each line is emitted with its 12-bit line address embedded in bits [511:500], together with a single-cycle write enable. This is the exact write format the banked memory consumes.
- Used for initial distance loads and for bulk write-back of updated vertex arrays.

Parameters:
- DATA_W, 32, lane width. Fixed by the line format.
- ADDR_W, 12, line address width. Must be 12 to fit bits [511:500].
- PAD_VALUE, 32'hFFFF_FFFF, fill value for lanes not written in a partial final line.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a transfer. Sampled only in IDLE.
- base_addr  in  ADDR_W  first line address. Latched on start.
- num_words  in  ADDR_W+5  number of values to pack, 0..65536. Latched on start.
- in_data  in  DATA_W  value stream.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  packer accepts in_data this cycle.
- data_out  out  512  packed line: lane i (i=0..14) at [32i+31:32i], lane 15 value [19:0] at [499:480], line address at [511:500].
- we_out  out  1  one-cycle write strobe qualifying data_out.
- busy  out  1  high from the accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the transfer is complete.

Behaviour:
- Reset values (asynchronous assert on rst_n=0): all outputs 0; state IDLE; lane counter 0; line buffer = PAD_VALUE in every lane.
- States: IDLE, FILL, EMIT, DONE.
- IDLE:
  - start=1 and num_words>0 → FILL. Latch line_addr=base_addr, remaining=num_words, lane=0, busy=1.
  - start=1 and num_words=0 → DONE. No write is issued.
  - start=0 → stay in IDLE.
- FILL:
  - in_ready=1.
  - A transfer occurs when in_valid and in_ready are both 1. It writes buf[lane]=in_data, then lane+1 and remaining-1.
  - If the transfer fills lane 15, or remaining reaches 0 → EMIT.
- EMIT (exactly 1 cycle):
  - in_ready=0.
  - we_out=1; data_out = {line_addr, buf[15][19:0], buf[14]..buf[0]}.
  - Lanes never written hold PAD_VALUE, with lane 15 carrying PAD_VALUE[19:0].
  - Next state: if remaining=0 → DONE. Otherwise → FILL with line_addr+1 (wraps 4095→0), lane=0, buffer refilled with PAD_VALUE.
- DONE (1 cycle): done=1, busy=0 on exit, then → IDLE.
- Latency:
  - A value accepted at cycle t that completes a line produces we_out at cycle t+1.
  - The last line's we_out at t+1 is followed by done at t+2.
  - Sustained throughput is 16 values per 17 cycles.
- data_out holds its last value when we_out=0. Consumers qualify it with we_out only.
- start while busy: ignored. base_addr and num_words are not re-latched.
- in_valid while in_ready=0: no transfer; in_data is not consumed.
- Lane 15 is truncated to [19:0] by default (see Optional Feature).
- rst_n asserted mid-transfer: immediate return to reset values. A partially filled line is discarded and no write is issued.

Optional Feature:
- Macro: BRAM_LINE_PACKER_SAT_LANE15_EN.
- Defined:
  - A lane-15 value above 20'hFFFFF is stored as 20'hFFFFF (saturating, so unreachable distances stay "infinite").
  - Adds output port lane15_ovf, 1 bit, sticky, set on any saturation. Cleared by reset and by an accepted start.
- Undefined: plain truncation to [19:0]; no lane15_ovf port.

Test Plan:
- start with base_addr=12'h005, num_words=16, values 0..15, in_valid held high → single we_out, 16 cycles after the first accept, data_out[511:500]=12'h005, lane i=i, [499:480]=20'h0000F; done on the next cycle.
- num_words=20, base_addr=12'hFFF, values 100..119 → line 0xFFF holds 100..115; line 0x000 (wrap) holds lanes 0..3=116..119 and lanes 4..14=FFFF_FFFF, [499:480]=20'hFFFFF; exactly 2 we_out pulses.
- in_valid toggled 1,0,1,0 during FILL → only valid-and-ready cycles advance the lane; packed contents are identical to the no-bubble run; in_ready=0 during every EMIT cycle.
- num_words=0 → no we_out; done one cycle after start; busy stays 0.
- rst_n pulsed low after 7 accepts of a 16-word transfer → outputs 0 immediately; no we_out; a new start with base_addr=12'h010 writes line 0x010 correctly.
- Lane 15 value 32'h0012_3456: without the macro → [499:480]=20'h23456; with BRAM_LINE_PACKER_SAT_LANE15_EN → 20'hFFFFF and lane15_ovf=1 until the next start.
